// File: rtl/voxel_projector.sv
// Ray-marching voxel renderer: walks the depth axis per screen pixel and writes the first hit colour
// to the framebuffer. Optional macro VOXEL_DEPTH_SHADE_EN darkens hits by their depth step.
module voxel_projector #(
    parameter int unsigned        GRID_BITS   = 3,
    parameter int unsigned        COLOR_W     = 8,
    parameter int unsigned        ADDR_W      = 12,
    parameter int unsigned        FB_ROW_BITS = 5,
    parameter int unsigned        FB_BASE     = 0,
    parameter logic [COLOR_W-1:0] BG_COLOR    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic                   vox_we,
    input  logic [3*GRID_BITS-1:0] vox_addr,
    input  logic [COLOR_W-1:0]     vox_wdata,
    output logic                   fb_we,
    output logic [ADDR_W-1:0]      fb_addr,
    output logic [COLOR_W-1:0]     fb_data,
    input  logic                   fb_ready,
    output logic                   busy,
    output logic                   done
);
    localparam int unsigned VA_W = 3 * GRID_BITS;

    typedef enum logic [2:0] {IDLE, READ, CHECK, WRITE, DONE} state_t;

    state_t               state;
    logic [GRID_BITS-1:0] u, v, d;
    logic [1:0]           mode_r;
    logic [COLOR_W-1:0]   vox_ram [0:(1<<VA_W)-1];
    logic [COLOR_W-1:0]   rd_data;
    logic [GRID_BITS-1:0] x, y, z;
    logic [VA_W-1:0]      rd_addr;
    logic [COLOR_W-1:0]   hit_color;
    logic [ADDR_W-1:0]    pix_addr;

    always_comb begin
        x = u;
        y = v;
        z = d;
        unique case (mode_r)
            2'd0: ;
            2'd1: begin y = d; z = v; end
            2'd2: begin x = d; z = u; end
            default: z = ~d;  // N-1-d, since N is a power of two
        endcase
        rd_addr = {z, y, x};
    end

`ifdef VOXEL_DEPTH_SHADE_EN
    logic [COLOR_W:0] shade_diff;
    always_comb begin
        shade_diff = {1'b0, rd_data} - (COLOR_W+1)'(d);
        hit_color  = (shade_diff[COLOR_W] || shade_diff == '0) ? COLOR_W'(1) : shade_diff[COLOR_W-1:0];
    end
`else
    always_comb hit_color = rd_data;
`endif

    always_comb pix_addr = ADDR_W'(FB_BASE) + (ADDR_W'(v) << FB_ROW_BITS) + ADDR_W'(u);

    // Voxel RAM has no reset so its contents survive a frame abort.
    always_ff @(posedge clk) begin
        if (vox_we && !busy)
            vox_ram[vox_addr] <= vox_wdata;
        if (state == READ)
            rd_data <= vox_ram[rd_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            u       <= '0;
            v       <= '0;
            d       <= '0;
            mode_r  <= '0;
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_r <= mode;
                        u      <= '0;
                        v      <= '0;
                        d      <= '0;
                        busy   <= 1'b1;
                        state  <= READ;
                    end
                end
                READ: state <= CHECK;
                CHECK: begin
                    if (rd_data != '0 || d == '1) begin
                        fb_we   <= 1'b1;
                        fb_addr <= pix_addr;
                        fb_data <= (rd_data != '0) ? hit_color : BG_COLOR;
                        state   <= WRITE;
                    end else begin
                        d     <= d + 1'b1;
                        state <= READ;
                    end
                end
                WRITE: begin
                    if (fb_ready) begin
                        fb_we <= 1'b0;
                        d     <= '0;
                        if (u == '1) begin
                            u <= '0;
                            if (v == '1) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                v     <= v + 1'b1;
                                state <= READ;
                            end
                        end else begin
                            u     <= u + 1'b1;
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_voxel_projector.sv
// Randomised bench for voxel_projector against a per-ray reference model of the cube.
module tb_voxel_projector;
    localparam int N   = 8;
    localparam int AW  = 12;
    localparam int RB  = 5;
    localparam int BASE = 0;
    localparam logic [7:0] BG = 8'h07;

    logic        clk = 1'b0;
    logic        reset, start, vox_we, fb_ready;
    logic [1:0]  mode;
    logic [8:0]  vox_addr;
    logic [7:0]  vox_wdata;
    logic        fb_we, busy, done;
    logic [11:0] fb_addr;
    logic [7:0]  fb_data;

    int compared = 0;
    int mismatched = 0;
    logic [7:0] cube [0:N-1][0:N-1][0:N-1];  // [z][y][x]

    voxel_projector #(
        .GRID_BITS(3), .COLOR_W(8), .ADDR_W(AW), .FB_ROW_BITS(RB), .FB_BASE(BASE), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .vox_we(vox_we), .vox_addr(vox_addr), .vox_wdata(vox_wdata),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ray(input int m, input int u, input int v, output int dh);
        int x, y, z;
        for (int d = 0; d < N; d++) begin
            case (m)
                0: begin x = u; y = v; z = d; end
                1: begin x = u; z = v; y = d; end
                2: begin z = u; y = v; x = d; end
                default: begin x = u; y = v; z = N - 1 - d; end
            endcase
            if (cube[z][y][x] != 0) begin
                dh = d;
`ifdef VOXEL_DEPTH_SHADE_EN
                return (int'(cube[z][y][x]) > d) ? 8'(int'(cube[z][y][x]) - d) : 8'd1;
`else
                return cube[z][y][x];
`endif
            end
        end
        dh = N - 1;
        return BG;
    endfunction

    function automatic logic [11:0] pix_addr(input int p);
        return 12'((BASE + ((p / N) << RB) + (p % N)) % (1 << AW));
    endfunction

    task automatic poke(input int x, input int y, input int z, input logic [7:0] c);
        vox_we    = 1'b1;
        vox_addr  = {3'(z), 3'(y), 3'(x)};
        vox_wdata = c;
        cube[z][y][x] = c;
        @(negedge clk);
        vox_we = 1'b0;
    endtask

    task automatic fill_cube(input bit rnd);
        for (int z = 0; z < N; z++)
            for (int y = 0; y < N; y++)
                for (int x = 0; x < N; x++)
                    poke(x, y, z, (rnd && $urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
    endtask

    // rmode: 0 always ready, 1 random ready, 2 five-cycle stall on the first write
    task automatic run_frame(input int m, input int rmode, input int abort_at, input bit inject, input bit chk_cycles);
        int nw = 0, ndone = 0, active = 0, expc = 1, dh, stall_left = 0, first_hold = 0, tail = -1;
        bit first_seen = 0, pstall = 0, aborted = 0, abort_pending = 0;
        logic [7:0] exp_d;
        for (int p = 0; p < N * N; p++) begin
            exp_d = ray(m, p % N, p / N, dh);
            expc += 2 * (dh + 1) + 1;
        end
        @(negedge clk);
        check("idle_busy", busy, 0);
        mode  = 2'(m);
        start = 1'b1;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            start  = 1'b0;
            vox_we = 1'b0;
            if (abort_pending) begin
                reset = 1'b1;
                #1;
                check("rst_fb_we", fb_we, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_fb_addr", fb_addr, 0);
                @(negedge clk);
                reset   = 1'b0;
                aborted = 1;
                break;
            end
            if (busy || done) active++;
            if (done) begin
                ndone++;
                check("busy_at_done", busy, 0);
                if (tail < 0) tail = 2;
            end
            case (rmode)
                0: fb_ready = 1'b1;
                1: fb_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (fb_we && !first_seen) begin first_seen = 1; stall_left = 5; end
                    if (stall_left > 0) begin fb_ready = 1'b0; stall_left--; end
                    else fb_ready = 1'b1;
                end
            endcase
            if (pstall) check("hold_we", fb_we, 1);
            if (fb_we) begin
                if (nw < N * N) begin
                    exp_d = ray(m, nw % N, nw / N, dh);
                    check("fb_addr", fb_addr, pix_addr(nw));
                    check("fb_data", fb_data, exp_d);
                end else begin
                    check("extra_write", nw, N * N - 1);
                end
                if (rmode == 2 && nw == 0) first_hold++;
                if (fb_ready) begin
                    nw++;
                    if (nw == abort_at) abort_pending = 1;
                end
            end
            pstall = fb_we && !fb_ready;
            if (inject && busy) begin
                start     = 1'($urandom_range(0, 1));
                mode      = 2'($urandom);
                vox_we    = 1'b1;
                vox_addr  = 9'($urandom);
                vox_wdata = 8'($urandom_range(1, 255));
            end
            if (tail == 0) break;
            if (tail > 0) tail--;
        end
        start = 1'b0;
        vox_we = 1'b0;
        fb_ready = 1'b1;
        if (!aborted) begin
            if (tail != 0) check("frame_timeout", 0, 1);
            check("write_count", nw, N * N);
            check("done_pulses", ndone, 1);
            if (rmode == 2) check("stall_hold", first_hold, 6);
            if (chk_cycles) check("frame_cycles", active, expc);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mode = '0; vox_we = 1'b0;
        vox_addr = '0; vox_wdata = '0; fb_ready = 1'b1;
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_fb_we", fb_we, 0);
        check("reset_fb_addr", fb_addr, 0);
        check("reset_fb_data", fb_data, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        reset = 1'b0;
        @(negedge clk);

        fill_cube(0);
        poke(2, 3, 5, 8'h2A);
        run_frame(0, 0, -1, 0, 1);
        run_frame(3, 0, -1, 0, 1);

        fill_cube(0);
        poke(1, 1, 2, 8'h10);
        poke(1, 1, 6, 8'h20);
        run_frame(0, 0, -1, 0, 1);
        run_frame(3, 0, -1, 0, 1);
        run_frame(1, 0, -1, 0, 1);
        run_frame(0, 2, -1, 0, 0);

        fill_cube(0);
        run_frame(0, 0, -1, 1, 1);
        run_frame(2, 0, -1, 0, 1);

        fill_cube(1);
        for (int m = 0; m < 4; m++) run_frame(m, 1, -1, 0, 0);
        run_frame(2, 0, -1, 0, 1);

        run_frame(1, 0, 20, 0, 0);
        run_frame(1, 0, -1, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
